ps2_scan_receiver: RTL and testbench

PS/2 device-to-host receiver, directly upstream of PS2KeyboardMemory. Synchronises and deglitches the raw ps2_clk/ps2_data pins and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop). Delivers each valid byte as scanCode with a one-cycle scanCodeReady strobe, which is exactly the interface PS2KeyboardMemory consumes. Malformed or stalled frames are dropped and flagged on frameError.

---
 rtl/ps2_scan_receiver.sv | 195 +++++++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver: synchronises and deglitches the raw pins,
// deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop)
// and presents each good byte with a one-cycle ready strobe. Bad or
// stalled frames are dropped and reported with a one-cycle error strobe.
`timescale 1ns/1ps

module ps2_scan_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scanCode,
    output logic       scanCodeReady,
    output logic       frameError,
    output logic       rxBusy
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTER_LEN);
    // The timeout fires on the cycle the idle counter would step onto
    // TIMEOUT_CYCLES-1, so the counter itself never holds that value and
    // never needs to wrap.
    localparam logic [IDLE_W-1:0] IDLE_PRE = IDLE_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Synchroniser stages, index 1 is the usable (metastability-safe) tap.
    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       sync_clk;
    logic       sync_data;

    // Deglitch filter and falling-edge detection.
    logic [FILT_W-1:0] filt_cnt;
    logic              filt_clk;
    logic              fall_strobe;

    // Frame state and its next-state values.
    state_t            state, state_next;
    logic [7:0]        shift_reg, shift_next;
    logic [2:0]        bit_cnt, bit_cnt_next;
    logic              parity_bit, parity_next;
    logic [IDLE_W-1:0] idle_cnt, idle_next;
    logic [7:0]        code_next;
    logic              ready_next;
    logic              error_next;
    logic              timeout_hit;

    assign sync_clk  = clk_sync[1];
    assign sync_data = data_sync[1];

    // Two-flop synchronisers on both asynchronous pins; idle level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Filtered clock flips only after the synchronised clock has disagreed
    // with it for FILTER_LEN cycles in a row; a 1->0 flip raises fall_strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_clk    <= 1'b1;
            filt_cnt    <= '0;
            fall_strobe <= 1'b0;
        end else begin
            fall_strobe <= 1'b0;
            if (sync_clk != filt_clk) begin
                if (filt_cnt == FILT_MAX) begin
                    filt_clk    <= sync_clk;
                    filt_cnt    <= '0;
                    fall_strobe <= filt_clk;
                end else begin
                    filt_cnt <= filt_cnt + FILT_W'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // A frame in progress that sees no falling edge for too long is stale.
    // A falling edge in the same cycle takes precedence.
    assign timeout_hit = (state != IDLE) && !fall_strobe && (idle_cnt == IDLE_PRE);

    // Next-state logic: the frame advances one bit per filtered falling edge.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        parity_next  = parity_bit;
        code_next    = scanCode;
        ready_next   = 1'b0;
        error_next   = 1'b0;

        if (state == IDLE || fall_strobe) begin
            idle_next = '0;
        end else begin
            idle_next = idle_cnt + IDLE_W'(1);
        end

        case (state)
            IDLE: begin
                if (fall_strobe) begin
                    if (!sync_data) begin
                        state_next   = DATA;
                        bit_cnt_next = 3'd0;
                    end else begin
                        // A high "start" bit cannot begin a frame.
                        error_next = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall_strobe) begin
                    shift_next = {sync_data, shift_reg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_next = 3'd0;
                        state_next   = PARITY;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (fall_strobe) begin
                    parity_next = sync_data;
                    state_next  = STOP;
                end
            end
            STOP: begin
                if (fall_strobe) begin
                    state_next = IDLE;
                    if (sync_data && (^{shift_reg, parity_bit})) begin
                        code_next  = shift_reg;
                        ready_next = 1'b1;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (timeout_hit) begin
            state_next   = IDLE;
            shift_next   = '0;
            bit_cnt_next = 3'd0;
            idle_next    = '0;
            error_next   = 1'b1;
        end
    end

    // State, datapath and registered output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shift_reg     <= '0;
            bit_cnt       <= 3'd0;
            parity_bit    <= 1'b0;
            idle_cnt      <= '0;
            scanCode      <= 8'h00;
            scanCodeReady <= 1'b0;
            frameError    <= 1'b0;
            rxBusy        <= 1'b0;
        end else begin
            state         <= state_next;
            shift_reg     <= shift_next;
            bit_cnt       <= bit_cnt_next;
            parity_bit    <= parity_next;
            idle_cnt      <= idle_next;
            scanCode      <= code_next;
            scanCodeReady <= ready_next;
            frameError    <= error_next;
            rxBusy        <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Testbench for ps2_scan_receiver: table of whole frames plus hand-written
// sequences for latency, timeout, glitches and mid-frame reset.
`timescale 1ns/1ps

module tb_ps2_scan_receiver;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 200;
    localparam int HALF           = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scanCode;
    logic       scanCodeReady;
    logic       frameError;
    logic       rxBusy;

    ps2_scan_receiver #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .scanCode(scanCode),
        .scanCodeReady(scanCodeReady),
        .frameError(frameError),
        .rxBusy(rxBusy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int rdy_cnt  = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    // Count strobe cycles away from the active edge.
    always @(negedge clk) begin
        if (scanCodeReady === 1'b1) rdy_cnt++;
        if (frameError === 1'b1) err_cnt++;
        if (scanCodeReady === 1'b1 && frameError === 1'b1) both_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        logic       pflip;
        logic       stop;
        int         exp_rdy;
        int         exp_err;
        logic [7:0] exp_code;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic pflip, input logic stop);
        return {stop, (~^d) ^ pflip, d, 1'b0};
    endfunction

    // Send the first nbits of a frame; optionally a 3-cycle low glitch is
    // placed in the high phase before bit glitch_bit.
    task automatic send_frame(input logic [10:0] fr, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            if (i == glitch_bit) begin
                tick(3);
                ps2_clk = 1'b0;
                tick(3);
                ps2_clk = 1'b1;
                tick(4);
            end else begin
                tick(HALF / 2);
            end
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
            tick(HALF / 2);
        end
    endtask

    initial begin
        logic [10:0] fr;
        int r0, e0, lat, to, busy_mid, busy_at, busy_first;

        vecs[0] = '{8'hF0, 1'b0, 1'b1, 1, 0, 8'hF0};
        vecs[1] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C};
        vecs[2] = '{8'hE0, 1'b0, 1'b1, 1, 0, 8'hE0};
        vecs[3] = '{8'h75, 1'b0, 1'b1, 1, 0, 8'h75};
        vecs[4] = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'h75};
        vecs[5] = '{8'h1C, 1'b0, 1'b0, 0, 1, 8'h75};
        vecs[6] = '{8'h00, 1'b0, 1'b1, 1, 0, 8'h00};
        vecs[7] = '{8'hFF, 1'b0, 1'b1, 1, 0, 8'hFF};

        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(3);
        check("reset_scanCode", int'(scanCode), 0);
        check("reset_ready", int'(scanCodeReady), 0);
        check("reset_error", int'(frameError), 0);
        check("reset_busy", int'(rxBusy), 0);
        rst = 1'b0;
        tick(5);

        // 0x1C with latency measured from the stop-bit pin fall.
        r0 = rdy_cnt; e0 = err_cnt;
        fr = make_frame(8'h1C, 1'b0, 1'b1);
        send_frame(fr, 10, -1);
        ps2_data = fr[10];
        tick(HALF / 2);
        ps2_clk = 1'b0;
        lat = -1; busy_first = -1;
        for (int c = 1; c <= HALF; c++) begin
            tick(1);
            if (c == 1) busy_first = int'(rxBusy);
            if (scanCodeReady && lat < 0) lat = c;
        end
        ps2_clk = 1'b1;
        tick(HALF / 2);
        check("lat_pin_to_ready", lat, FILTER_LEN + 4);
        check("lat_busy_in_stop", busy_first, 1);
        check("lat_ready_count", rdy_cnt - r0, 1);
        check("lat_error_count", err_cnt - e0, 0);
        check("lat_scanCode", int'(scanCode), 8'h1C);
        check("lat_busy_after", int'(rxBusy), 0);

        // Table of back-to-back frames.
        for (int v = 0; v < 8; v++) begin
            r0 = rdy_cnt; e0 = err_cnt;
            send_frame(make_frame(vecs[v].data, vecs[v].pflip, vecs[v].stop), 11, -1);
            check($sformatf("vec%0d_ready", v), rdy_cnt - r0, vecs[v].exp_rdy);
            check($sformatf("vec%0d_error", v), err_cnt - e0, vecs[v].exp_err);
            check($sformatf("vec%0d_scanCode", v), int'(scanCode), int'(vecs[v].exp_code));
            check($sformatf("vec%0d_busy", v), int'(rxBusy), 0);
        end

        // Stray falling edge with data high while idle.
        r0 = rdy_cnt; e0 = err_cnt;
        send_frame(11'h7FF, 1, -1);
        check("stray_error", err_cnt - e0, 1);
        check("stray_ready", rdy_cnt - r0, 0);
        check("stray_scanCode", int'(scanCode), 8'hFF);

        // Timeout: start + 4 data bits, then clock held high.
        r0 = rdy_cnt; e0 = err_cnt;
        fr = make_frame(8'h29, 1'b0, 1'b1);
        send_frame(fr, 4, -1);
        ps2_data = fr[4];
        tick(HALF / 2);
        ps2_clk = 1'b0;
        to = -1; busy_mid = -1; busy_at = -1;
        for (int c = 1; c <= 300; c++) begin
            tick(1);
            if (c == HALF) ps2_clk = 1'b1;
            if (c == 100) busy_mid = int'(rxBusy);
            if (frameError && to < 0) begin
                to = c;
                busy_at = int'(rxBusy);
            end
        end
        check("timeout_latency", to, FILTER_LEN + 4 + TIMEOUT_CYCLES - 1);
        check("timeout_busy_mid", busy_mid, 1);
        check("timeout_busy_drop", busy_at, 0);
        check("timeout_error", err_cnt - e0, 1);
        check("timeout_ready", rdy_cnt - r0, 0);

        r0 = rdy_cnt; e0 = err_cnt;
        send_frame(make_frame(8'h29, 1'b0, 1'b1), 11, -1);
        check("after_to_ready", rdy_cnt - r0, 1);
        check("after_to_error", err_cnt - e0, 0);
        check("after_to_scanCode", int'(scanCode), 8'h29);

        // Glitches: one on the idle line, one inside the data phase of 0x12.
        r0 = rdy_cnt; e0 = err_cnt;
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(20);
        check("idle_glitch_error", err_cnt - e0, 0);
        check("idle_glitch_busy", int'(rxBusy), 0);
        send_frame(make_frame(8'h12, 1'b0, 1'b1), 11, 3);
        check("glitch_ready", rdy_cnt - r0, 1);
        check("glitch_error", err_cnt - e0, 0);
        check("glitch_scanCode", int'(scanCode), 8'h12);

        // Reset after the 5th data bit, then a fresh frame.
        r0 = rdy_cnt; e0 = err_cnt;
        send_frame(make_frame(8'h33, 1'b0, 1'b1), 6, -1);
        check("pre_rst_busy", int'(rxBusy), 1);
        ps2_data = 1'b1;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_scanCode", int'(scanCode), 0);
        check("rst_ready", int'(scanCodeReady), 0);
        check("rst_error", int'(frameError), 0);
        check("rst_busy", int'(rxBusy), 0);
        tick(50);
        check("rst_no_ready", rdy_cnt - r0, 0);
        check("rst_no_error", err_cnt - e0, 0);
        send_frame(make_frame(8'h5A, 1'b0, 1'b1), 11, -1);
        check("post_rst_ready", rdy_cnt - r0, 1);
        check("post_rst_error", err_cnt - e0, 0);
        check("post_rst_scanCode", int'(scanCode), 8'h5A);

        check("ready_error_overlap", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
